bridge_txn_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one AXI4-Lite transaction engine (the single-word AXI master used by the UART bridge) between NUM_REQ command requesters: UART frame path, on-chip debug/self-test, etc. Accepts one request at a time, issues it to the engine with a single-cycle start pulse, supervises completion with a watchdog backstop and returns status and read data to the granted requester. Sits between the requesters' control FSMs and the engine's start/done interface.

---
 rtl/bridge_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 35 +++
 rtl/bridge_txn_arbiter.sv | 140 ++++++++++++++
 tb/tb_bridge_txn_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_arb_pkg.sv
// Shared types and constants for the AXI-Lite transaction arbiter.
package bridge_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESPOND   = 2'd3
  } arb_state_t;

  localparam logic [7:0] ARB_STATUS_TIMEOUT = 8'h04;
  localparam int         CMD_RW_BIT         = 7;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: highest priority goes to last_grant+1.
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDXW = $clog2(NUM_REQ);

  function automatic logic [IDXW-1:0] slot(input logic [IDXW-1:0] last, input int k);
    int s;
    s = (int'(last) + k) % NUM_REQ;
    return IDXW'(s);
  endfunction

  // Walk from lowest to highest priority so the nearest requester overwrites.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_i[slot(last_grant_i, k)]) begin
        grant_o                        = '0;
        grant_o[slot(last_grant_i, k)] = 1'b1;
        idx_o                          = slot(last_grant_i, k);
        any_o                          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bridge_txn_arbiter.sv
// Shares one single-word AXI-Lite engine between NUM_REQ requesters with
// round-robin arbitration, a watchdog backstop and per-requester responses.
module bridge_txn_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int WATCHDOG_CYCLES = 2000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][7:0]       req_cmd,
  input  logic [NUM_REQ-1:0][31:0]      req_addr,
  input  logic [NUM_REQ-1:0][31:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [7:0]                    rsp_status,
  output logic [31:0]                   rsp_rdata,
  output logic                          eng_start,
  output logic                          eng_abort,
  output logic [7:0]                    eng_cmd,
  output logic [31:0]                   eng_addr,
  output logic [31:0]                   eng_wdata,
  input  logic                          eng_done,
  input  logic [7:0]                    eng_status,
  input  logic [31:0]                   eng_rdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          arb_busy,
  output logic [7:0]                    timeout_count
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int WDW  = $clog2(WATCHDOG_CYCLES + 1);

  arb_state_t         state_q;
  logic [IDXW-1:0]    grant_id_q, last_grant_q;
  logic [7:0]         cmd_q, status_q, tcount_q, tcount_d;
  logic [31:0]        addr_q, wdata_q, rdata_q, rdata_d;
  logic               eng_start_q;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_onehot;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               wd_expired, abort_hit;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_any;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .idx_o        (pick_idx),
    .any_o        (pick_any)
  );

  assign wd_expired = (wd_q == WDW'(WATCHDOG_CYCLES - 1));
  // Saturate rather than wrap so a stuck count can never re-arm the expiry.
  assign wd_d       = (wd_q == WDW'(WATCHDOG_CYCLES)) ? wd_q : wd_q + WDW'(1);
  assign tcount_d   = sat_inc8(tcount_q);
  assign rsp_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
  // Only successful reads return data; writes and errors return zero.
  assign rdata_d    = (cmd_q[CMD_RW_BIT] && eng_status == 8'h00) ? eng_rdata : '0;
  // A done arriving on the expiry cycle beats the abort.
  assign abort_hit  = !rst && state_q == ST_WAIT_DONE && !eng_done && wd_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDXW'(NUM_REQ - 1);
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      status_q     <= '0;
      rdata_q      <= '0;
      tcount_q     <= '0;
      wd_q         <= '0;
      eng_start_q  <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id_q  <= pick_idx;
            cmd_q       <= req_cmd[pick_idx];
            addr_q      <= req_addr[pick_idx];
            wdata_q     <= req_wdata[pick_idx];
            eng_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_q    <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (eng_done) begin
            status_q    <= eng_status;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_onehot;
            state_q     <= ST_RESPOND;
          end else if (wd_expired) begin
            status_q    <= ARB_STATUS_TIMEOUT;
            rdata_q     <= '0;
            tcount_q    <= tcount_d;
            rsp_valid_q <= rsp_onehot;
            state_q     <= ST_RESPOND;
          end else begin
            wd_q <= wd_d;
          end
        end
        ST_RESPOND: begin
          last_grant_q <= grant_id_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE && !rst) ? pick_grant : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = status_q;
  assign rsp_rdata     = rdata_q;
  assign eng_start     = eng_start_q;
  assign eng_abort     = abort_hit;
  assign eng_cmd       = cmd_q;
  assign eng_addr      = addr_q;
  assign eng_wdata     = wdata_q;
  assign grant_id      = grant_id_q;
  assign arb_busy      = (state_q != ST_IDLE);
  assign timeout_count = tcount_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_start_issue:  assert property (@(posedge clk) disable iff (rst) eng_start |-> state_q == ST_ISSUE);

endmodule

// File: tb/tb_bridge_txn_arbiter.sv
// Scoreboard bench for bridge_txn_arbiter: directed requests, engine model, response monitor.
module tb_bridge_txn_arbiter;

  localparam int NREQ = 2;
  localparam int WD   = 16;
  localparam int IW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][7:0]   req_cmd;
  logic [NREQ-1:0][31:0]  req_addr;
  logic [NREQ-1:0][31:0]  req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [7:0]             rsp_status;
  logic [31:0]            rsp_rdata;
  logic                   eng_start, eng_abort;
  logic [7:0]             eng_cmd;
  logic [31:0]            eng_addr, eng_wdata;
  logic                   eng_done;
  logic [7:0]             eng_status;
  logic [31:0]            eng_rdata;
  logic [IW-1:0]          grant_id;
  logic                   arb_busy;
  logic [7:0]             timeout_count;

  bridge_txn_arbiter #(.NUM_REQ(NREQ), .WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_cmd(eng_cmd), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_status(eng_status), .eng_rdata(eng_rdata),
    .grant_id(grant_id), .arb_busy(arb_busy), .timeout_count(timeout_count)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [7:0]    status;
    logic [31:0]   rdata;
    int            acc_cyc;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] grant_log[$];
  int n_vec = 0, n_bad = 0, cyc = 0;
  int cfg_lat = 1;
  logic [7:0]  cfg_stat = 8'h00;
  logic [31:0] cfg_rd = 32'h0;
  int acc_cyc = 0, start_cyc = 0, abort_cyc = 0, abort_cnt = 0;
  logic [7:0]  acc_cmd = 8'h0;
  logic [31:0] acc_addr = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Engine model: done pulse cfg_lat cycles after the start cycle (0 = never).
  initial begin
    int done_in;
    done_in = -1;
    eng_done = 1'b0; eng_status = 8'h00; eng_rdata = 32'h0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0; eng_status = 8'hEE; eng_rdata = 32'hBAD0BAD0;
      if (rst) done_in = -1;
      else begin
        if (done_in > 0) begin
          done_in--;
          if (done_in == 0) begin
            eng_done = 1'b1; eng_status = cfg_stat; eng_rdata = cfg_rd; done_in = -1;
          end
        end
        if (eng_start) begin
          start_cyc = cyc;
          chk("start_latency", 64'(cyc), 64'(acc_cyc + 1));
          chk("eng_addr", 64'(eng_addr), 64'(acc_addr));
          chk("eng_cmd", 64'(eng_cmd), 64'(acc_cmd));
          if (cfg_lat > 0) done_in = cfg_lat;
        end
      end
    end
  end

  // Response monitor, sampled after the engine model has driven this cycle.
  initial begin
    exp_t e;
    logic [NREQ-1:0] one;
    forever begin
      @(negedge clk);
      #2;
      if (eng_abort) begin abort_cnt++; abort_cyc = cyc; end
      if (!rst && rsp_valid != '0) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
        end else begin
          e = sb.pop_front();
          one = '0; one[e.id] = 1'b1;
          chk("rsp_valid_id", 64'(rsp_valid), 64'(one));
          chk("rsp_status", 64'(rsp_status), 64'(e.status));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input logic [IW-1:0] id, input logic [7:0] cmd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] es, input logic [31:0] erd,
                       input int lat, input bit push);
    exp_t e;
    int k;
    req_cmd[id] = cmd; req_addr[id] = addr; req_wdata[id] = wdata; req_valid[id] = 1'b1;
    for (k = 0; k < 200; k++) begin
      #1;
      if (req_ready[id]) break;
      @(negedge clk);
    end
    if (k == 200) begin
      fail_now("accept_timeout");
      req_valid[id] = 1'b0;
      return;
    end
    acc_cyc = cyc; acc_cmd = cmd; acc_addr = addr;
    grant_log.push_back(id);
    if (push) begin
      e.id = id; e.status = es; e.rdata = erd; e.acc_cyc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !arb_busy) break;
      @(negedge clk);
    end
    if (k == 100) fail_now("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int ac;
    req_valid = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("reset_ctrl", 64'({req_ready, rsp_valid, eng_start, eng_abort, arb_busy, grant_id}), 64'(0));
    chk("reset_tcount", 64'(timeout_count), 64'(0));
    chk("reset_eng_addr", 64'(eng_addr), 64'(0));
    chk("reset_eng_cmd_wdata", 64'({eng_cmd, eng_wdata}), 64'(0));
    chk("reset_rsp", 64'({rsp_status, rsp_rdata}), 64'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single read
    cfg_lat = 5; cfg_stat = 8'h00; cfg_rd = 32'hDEADBEEF;
    issue(1'b0, 8'h80, 32'h1000, 32'h0, 8'h00, 32'hDEADBEEF, 7, 1'b1);
    drain();

    // write with engine error: status passes through, data forced to zero
    cfg_lat = 3; cfg_stat = 8'h03; cfg_rd = 32'h12345678;
    issue(1'b1, 8'h00, 32'h2000, 32'h55AA55AA, 8'h03, 32'h0, 5, 1'b1);
    drain();

    // contention: both continuously valid
    cfg_lat = 3; cfg_stat = 8'h00; cfg_rd = 32'hA5A50001;
    grant_log.delete();
    fork
      begin
        issue(1'b0, 8'h80, 32'h3000, 32'h0, 8'h00, 32'hA5A50001, -1, 1'b1);
        issue(1'b0, 8'h80, 32'h3004, 32'h0, 8'h00, 32'hA5A50001, -1, 1'b1);
      end
      begin
        issue(1'b1, 8'h01, 32'h4000, 32'h1111, 8'h00, 32'h0, -1, 1'b1);
        issue(1'b1, 8'h01, 32'h4004, 32'h2222, 8'h00, 32'h0, -1, 1'b1);
      end
    join
    drain();
    chk("grant_order_len", 64'(grant_log.size()), 64'(4));
    for (int i = 0; i < grant_log.size(); i++) chk("grant_order", 64'(grant_log[i]), 64'(i % 2));
    chk("grant_id_last", 64'(grant_id), 64'(1));

    // watchdog expiry
    cfg_lat = 0; ac = abort_cnt;
    issue(1'b0, 8'h80, 32'h5000, 32'h0, 8'h04, 32'h0, 18, 1'b1);
    drain();
    chk("abort_pulses", 64'(abort_cnt - ac), 64'(1));
    chk("abort_cycle", 64'(abort_cyc - start_cyc), 64'(16));
    chk("timeout_count_1", 64'(timeout_count), 64'(1));

    // done coincident with expiry
    cfg_lat = 16; cfg_stat = 8'h00; cfg_rd = 32'hCAFEF00D; ac = abort_cnt;
    issue(1'b0, 8'h80, 32'h6000, 32'h0, 8'h00, 32'hCAFEF00D, 18, 1'b1);
    drain();
    chk("race_no_abort", 64'(abort_cnt - ac), 64'(0));
    chk("race_tcount", 64'(timeout_count), 64'(1));

    // saturation: 255 total timeouts, then 45 more
    cfg_lat = 0;
    for (int i = 0; i < 254; i++) issue(1'b0, 8'h00, 32'h7000 + i, 32'(i), 8'h04, 32'h0, 18, 1'b1);
    drain();
    chk("tcount_255", 64'(timeout_count), 64'(8'hFF));
    for (int i = 0; i < 45; i++) issue(1'b0, 8'h80, 32'h7800 + i, 32'h0, 8'h04, 32'h0, 18, 1'b1);
    drain();
    chk("tcount_sat_300", 64'(timeout_count), 64'(8'hFF));

    // reset while waiting on the engine
    cfg_lat = 0;
    issue(1'b0, 8'h80, 32'h8000, 32'h0, 8'h00, 32'h0, -1, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(arb_busy), 64'(1));
    ac = abort_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(arb_busy), 64'(0));
    chk("rst_tcount", 64'(timeout_count), 64'(0));
    chk("rst_rsp", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk("rst_no_abort", 64'(abort_cnt - ac), 64'(0));

    // after reset requester 0 wins first again
    cfg_lat = 2; cfg_stat = 8'h00; cfg_rd = 32'h0BADF00D;
    grant_log.delete();
    fork
      issue(1'b0, 8'h80, 32'h9000, 32'h0, 8'h00, 32'h0BADF00D, 4, 1'b1);
      issue(1'b1, 8'h80, 32'h9004, 32'h0, 8'h00, 32'h0BADF00D, -1, 1'b1);
    join
    drain();
    chk("post_rst_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() > 0) chk("post_rst_first", 64'(grant_log[0]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
